// File: rtl/bist_pattern_driver.sv
// bist_pattern_driver
//   Built-in self-test driver for one combinational benchmark netlist.
//   A 16-bit Fibonacci LFSR drives pseudo-random patterns into the netlist
//   inputs. A 16-bit MISR compacts the netlist responses into a signature,
//   which is compared against GOLDEN_SIG when the run completes.
//
//   Optional build macro: BIST_STUCK_CHECK_EN
//     When it is defined, every output bit is also tracked for the whole run.
//     A bit that never toggles is flagged in stuck_mask, and any flagged bit
//     forces pass low. When it is undefined, stuck_mask is tied to zero.
//
// Ports
//   clk        : single clock
//   rst        : synchronous, active-high reset
//   start      : begin a run (only sampled in IDLE or DONE)
//   pat_out    : pattern to the netlist inputs (bit 0 = first input)
//   resp_in    : netlist outputs (bit 0 = first output)
//   busy       : high while patterns are being applied
//   done       : high in DONE until the next start is accepted
//   signature  : current MISR contents
//   pass       : valid while done=1
//   stuck_mask : per-output-bit "never toggled" flags (macro build only)
module bist_pattern_driver #(
    parameter int          N_IN        = 14,
    parameter int          N_OUT       = 8,
    parameter int          PATTERN_CNT = 256,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  pat_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic             pass,
    output logic [N_OUT-1:0] stuck_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] LAST = 16'(PATTERN_CNT - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] cnt;
    logic [15:0] lfsr_next;
    logic [15:0] sig_next;
    logic        stuck_ok;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign sig_next  = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
                       ^ 16'(resp_in);

`ifdef BIST_STUCK_CHECK_EN
    logic [N_OUT-1:0] first_val;
    logic [N_OUT-1:0] stuck_next;

    // The first sample of a run arms every bit.
    // A later sample that differs from the first one clears that bit.
    assign stuck_next = (cnt == 16'd0) ? {N_OUT{1'b1}} : (stuck_mask & ~(resp_in ^ first_val));
    assign stuck_ok   = (stuck_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            first_val  <= '0;
            stuck_mask <= '0;
        end else if (state != RUN && start) begin
            first_val  <= '0;
            stuck_mask <= '0;
        end else if (state == RUN) begin
            if (cnt == 16'd0) first_val <= resp_in;
            stuck_mask <= stuck_next;
        end
    end
`else
    assign stuck_mask = '0;
    assign stuck_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
            lfsr      <= LFSR_SEED;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        lfsr      <= LFSR_SEED;
                        pat_out   <= LFSR_SEED[N_IN-1:0];
                        signature <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    // The netlist is combinational, so resp_in is the response
                    // to the pat_out value held during this cycle.
                    signature <= sig_next;
                    lfsr      <= lfsr_next;
                    pat_out   <= lfsr_next[N_IN-1:0];
                    cnt       <= cnt + 16'd1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_next == GOLDEN_SIG) && stuck_ok;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Self-checking bench for bist_pattern_driver.
// u_main runs with the default parameters and drives a small combinational
// function that stands in for the netlist. u_p1 and u_p2 cover PATTERN_CNT=1
// and PATTERN_CNT=2 with a constant response of 8'hA5.
module tb_bist_pattern_driver;

`ifdef BIST_STUCK_CHECK_EN
    localparam bit STUCK = 1'b1;
`else
    localparam bit STUCK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_m, start_1, start_2;
    logic [1:0]  mode;
    logic [13:0] pat_m, pat_1, pat_2;
    logic [7:0]  resp_m, resp_c;
    logic        busy_m, busy_1, busy_2, done_m, done_1, done_2, pass_m, pass_1, pass_2;
    logic [15:0] sig_m, sig_1, sig_2;
    logic [7:0]  stk_m, stk_1, stk_2;

    int checks = 0;
    int failures = 0;

    logic [13:0] pat_q[$];
    logic [15:0] sig_q[$];
    logic [7:0]  mask_q[$];

    function automatic logic [7:0] netlist(input logic [1:0] md, input logic [13:0] p);
        case (md)
            2'd0:    return 8'h00;
            2'd1:    return p[7:0] ^ {p[13:8], p[1:0]} ^ 8'h3C;
            default: return 8'hA5;
        endcase
    endfunction

    assign resp_m = netlist(mode, pat_m);
    assign resp_c = 8'hA5;

    bist_pattern_driver u_main (
        .clk(clk), .rst(rst), .start(start_m), .pat_out(pat_m), .resp_in(resp_m),
        .busy(busy_m), .done(done_m), .signature(sig_m), .pass(pass_m), .stuck_mask(stk_m));

    bist_pattern_driver #(.PATTERN_CNT(1), .GOLDEN_SIG(16'h00A5)) u_p1 (
        .clk(clk), .rst(rst), .start(start_1), .pat_out(pat_1), .resp_in(resp_c),
        .busy(busy_1), .done(done_1), .signature(sig_1), .pass(pass_1), .stuck_mask(stk_1));

    bist_pattern_driver #(.PATTERN_CNT(2)) u_p2 (
        .clk(clk), .rst(rst), .start(start_2), .pat_out(pat_2), .resp_in(resp_c),
        .busy(busy_2), .done(done_2), .signature(sig_2), .pass(pass_2), .stuck_mask(stk_2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard producer: the pattern stream, final signature and stuck mask for one run.
    task automatic model_run(input logic [1:0] md, input int n);
        logic [15:0] l, m;
        logic [7:0]  r, first, mask;
        l = 16'hACE1; m = '0; mask = '0; first = '0;
        for (int k = 0; k < n; k++) begin
            pat_q.push_back(l[13:0]);
            r = netlist(md, l[13:0]);
            if (k == 0) begin first = r; mask = 8'hFF; end
            else mask = mask & ~(r ^ first);
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {8'h00, r};
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        sig_q.push_back(m);
        mask_q.push_back(mask);
    endtask

    // Consumes u_main samples until done. The caller has already sampled
    // nb0 busy cycles. start_m is driven with hold, plus a one-cycle pulse
    // at iteration pulse_at.
    task automatic drain_main(input string tag, input int nb0, input int pulse_at, input bit hold);
        int nb;
        bit got_done;
        logic [15:0] es;
        logic [7:0]  em;
        nb = nb0; got_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (done_m) begin got_done = 1'b1; break; end
            if (busy_m) begin
                if (pat_q.size() > 0) chk({tag, "_pat"}, pat_m, pat_q.pop_front());
                nb++;
            end
            start_m = hold || (c == pulse_at);
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, got_done, 1'b1);
        chk({tag, "_busy_cycles"}, nb, 256);
        chk({tag, "_pat_q_left"}, pat_q.size(), 0);
        es = sig_q.pop_front();
        em = mask_q.pop_front();
        chk({tag, "_sig"}, sig_m, es);
        chk({tag, "_stuck"}, stk_m, STUCK ? em : 8'h00);
        chk({tag, "_pass"}, pass_m, (es == 16'h0000) && (!STUCK || em == 8'h00));
    endtask

    initial begin
        logic [15:0] s1;
        rst = 1'b1; start_m = 1'b0; start_1 = 1'b0; start_2 = 1'b0; mode = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pat", pat_m, 14'h0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        chk("rst_pass", pass_m, 1'b0);
        chk("rst_sig", sig_m, 16'h0);
        chk("rst_stuck", stk_m, 8'h0);
        chk("rst_p1_done", done_1, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // First run: explicit seed checks, then a start pulse in mid-run that must be ignored.
        model_run(2'd1, 256);
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        chk("run1_pat0", pat_m, 14'h2CE1);
        chk("run1_busy0", busy_m, 1'b1);
        chk("run1_q0", pat_m, pat_q.pop_front());
        @(posedge clk); #1;
        chk("run1_pat1", pat_m, 14'h19C3);
        drain_main("run1", 1, 50, 1'b0);
        start_m = 1'b0;
        @(posedge clk); #1;
        chk("run1_done_hold", done_m, 1'b1);

        // All-zero response.
        mode = 2'd0;
        model_run(2'd0, 256);
        start_m = 1'b1;
        @(posedge clk); #1;
        drain_main("zero", 0, -1, 1'b0);
        chk("zero_sig_const", sig_m, 16'h0000);
        chk("zero_pass_const", pass_m, !STUCK);
        chk("zero_stuck_const", stk_m, STUCK ? 8'hFF : 8'h00);

        // Reset in the middle of a run.
        mode = 2'd1;
        model_run(2'd1, 256);
        start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        for (int k = 0; k < 100; k++) begin
            chk("mid_pat", pat_m, pat_q.pop_front());
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", busy_m, 1'b0);
        chk("mid_rst_done", done_m, 1'b0);
        chk("mid_rst_sig", sig_m, 16'h0);
        chk("mid_rst_pat", pat_m, 14'h0);
        chk("mid_rst_pass", pass_m, 1'b0);
        pat_q.delete(); sig_q.delete(); mask_q.delete();
        model_run(2'd1, 256);
        start_m = 1'b1;
        @(posedge clk); #1;
        chk("rerun_pat0", pat_m, 14'h2CE1);
        drain_main("rerun", 0, -1, 1'b0);
        start_m = 1'b0;
        @(posedge clk); #1;

        // Back-to-back runs with start held high.
        model_run(2'd1, 256);
        start_m = 1'b1;
        @(posedge clk); #1;
        drain_main("b2b1", 0, -1, 1'b1);
        s1 = sig_m;
        model_run(2'd1, 256);
        @(posedge clk); #1;
        chk("b2b_gap_done", done_m, 1'b0);
        chk("b2b_gap_busy", busy_m, 1'b1);
        drain_main("b2b2", 0, -1, 1'b1);
        start_m = 1'b0;
        chk("b2b_same_sig", sig_m, s1);

        // PATTERN_CNT=1 and PATTERN_CNT=2 with a constant response of 8'hA5.
        start_1 = 1'b1; start_2 = 1'b1;
        @(posedge clk); #1;
        start_1 = 1'b0; start_2 = 1'b0;
        chk("p1_busy_c0", busy_1, 1'b1);
        chk("p2_busy_c0", busy_2, 1'b1);
        @(posedge clk); #1;
        chk("p1_busy_c1", busy_1, 1'b0);
        chk("p1_done", done_1, 1'b1);
        chk("p1_sig", sig_1, 16'h00A5);
        chk("p1_pass", pass_1, !STUCK);
        chk("p1_stuck", stk_1, STUCK ? 8'hFF : 8'h00);
        chk("p2_busy_c1", busy_2, 1'b1);
        chk("p2_done_c1", done_2, 1'b0);
        @(posedge clk); #1;
        chk("p2_busy_c2", busy_2, 1'b0);
        chk("p2_done", done_2, 1'b1);
        chk("p2_sig", sig_2, 16'h01EF);
        chk("p2_pass", pass_2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
